uart_rx_ctrl: RTL and testbench



---
 rtl/uart_rx_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_ctrl
//  Purpose  : Register-mapped controller for the uart_rx receiver. Drives the
//             receiver configuration from CTRL/BAUD, captures completed frames
//             into a circular RX FIFO, and exposes status, sticky error flags
//             and a registered level interrupt.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
  parameter int unsigned FifoDepth  = 16,
  parameter logic [31:0] DefaultDiv = 32'd433
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        device_req_i,
  input  logic [31:0] device_addr_i,
  input  logic        device_we_i,
  input  logic [3:0]  device_be_i,
  input  logic [31:0] device_wdata_i,
  output logic        device_rvalid_o,
  output logic [31:0] device_rdata_o,
  output logic        rx_en_o,
  output logic [31:0] baud_rate_o,
  output logic [3:0]  data_size_o,
  output logic        parity_size_o,
  output logic        parity_type_o,
  output logic [1:0]  stop_size_o,
  input  logic [8:0]  rx_data_i,
  input  logic        rx_rdy_i,
  input  logic        rx_err_i,
  output logic        irq_o
);

  localparam int unsigned AW = $clog2(FifoDepth);
  localparam int unsigned CW = AW + 1;

  localparam logic [2:0] RegRdata  = 3'd0;
  localparam logic [2:0] RegStatus = 3'd1;
  localparam logic [2:0] RegCtrl   = 3'd2;
  localparam logic [2:0] RegBaud   = 3'd3;
  localparam logic [2:0] RegLevel  = 3'd4;

  localparam logic [CW-1:0] FullCount = CW'(FifoDepth);

  // Configuration registers
  logic          en_q,           en_d;
  logic [3:0]    data_size_q,    data_size_d;
  logic          parity_size_q,  parity_size_d;
  logic          parity_type_q,  parity_type_d;
  logic [1:0]    stop_size_q,    stop_size_d;
  logic          irq_en_level_q, irq_en_level_d;
  logic          irq_en_err_q,   irq_en_err_d;
  logic [3:0]    watermark_q,    watermark_d;
  logic [31:0]   baud_q,         baud_d;

  // FIFO bookkeeping and status
  logic [AW-1:0] wptr_q,  wptr_d;
  logic [AW-1:0] rptr_q,  rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q,   ovf_d;
  logic          perr_q,  perr_d;
  logic          rdy_prev_q, rdy_prev_d;

  // Bus response and interrupt
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q,  rdata_d;
  logic          irq_q,    irq_d;

  // Frame storage: {parity error, data[8:0]} per entry
  logic [9:0]    mem_q [FifoDepth];

  // Decode and datapath control signals
  logic [2:0]    sel;
  logic          wr_req;
  logic          rd_req;
  logic          empty;
  logic          full;
  logic          strobe;
  logic          flush;
  logic          pop;
  logic          push;
  logic          drop;
  logic [6:0]    level;
  logic [31:0]   rd_mux;

  // Address bits outside [4:2] carry no meaning for this block
  logic          unused_addr;
  assign unused_addr = ^{device_addr_i[31:5], device_addr_i[1:0]};

  // Bus decode, FIFO control and flag next-state logic
  always_comb begin
    sel    = device_addr_i[4:2];
    wr_req = device_req_i & device_we_i;
    rd_req = device_req_i & ~device_we_i;
    empty  = (count_q == '0);
    full   = (count_q == FullCount);
    level  = 7'(count_q);

    // Capture on the rising edge of the receiver's ready level so that one
    // high period of any length produces exactly one push.
    strobe = rx_rdy_i & ~rdy_prev_q;
    flush  = wr_req & (sel == RegCtrl) & device_be_i[3] & device_wdata_i[31];
    pop    = rd_req & (sel == RegRdata) & ~empty;
    // A pop in the same cycle frees the slot the push lands in, so a full
    // FIFO still accepts the frame; flush discards any same-cycle push.
    push   = strobe & ~flush & (~full | pop);
    drop   = strobe & ~flush & full & ~pop;

    rdy_prev_d = rx_rdy_i;

    // Pointer and occupancy update
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end

    // Sticky flags: a same-cycle set wins over a software clear
    ovf_d  = ovf_q;
    perr_d = perr_q;
    if (wr_req && (sel == RegStatus) && device_be_i[0]) begin
      if (device_wdata_i[2]) ovf_d  = 1'b0;
      if (device_wdata_i[3]) perr_d = 1'b0;
    end
    if (drop)               ovf_d  = 1'b1;
    if (strobe && rx_err_i) perr_d = 1'b1;
  end

  // Configuration register writes with byte enables
  always_comb begin
    en_d           = en_q;
    data_size_d    = data_size_q;
    parity_size_d  = parity_size_q;
    parity_type_d  = parity_type_q;
    stop_size_d    = stop_size_q;
    irq_en_level_d = irq_en_level_q;
    irq_en_err_d   = irq_en_err_q;
    watermark_d    = watermark_q;
    baud_d         = baud_q;
    if (wr_req && (sel == RegCtrl)) begin
      if (device_be_i[0]) begin
        en_d        = device_wdata_i[0];
        data_size_d = device_wdata_i[7:4];
      end
      if (device_be_i[1]) begin
        parity_size_d = device_wdata_i[8];
        parity_type_d = device_wdata_i[9];
        stop_size_d   = device_wdata_i[11:10];
      end
      if (device_be_i[2]) begin
        irq_en_level_d = device_wdata_i[16];
        irq_en_err_d   = device_wdata_i[17];
        watermark_d    = device_wdata_i[23:20];
      end
    end
    if (wr_req && (sel == RegBaud)) begin
      if (device_be_i[0]) baud_d[7:0]   = device_wdata_i[7:0];
      if (device_be_i[1]) baud_d[15:8]  = device_wdata_i[15:8];
      if (device_be_i[2]) baud_d[23:16] = device_wdata_i[23:16];
      if (device_be_i[3]) baud_d[31:24] = device_wdata_i[31:24];
    end
  end

  // Read mux, bus response and interrupt next-state
  always_comb begin
    rd_mux = 32'h0;
    case (sel)
      RegRdata:  rd_mux = empty ? 32'h8000_0000 : {22'h0, mem_q[rptr_q]};
      RegStatus: rd_mux = {28'h0, perr_q, ovf_q, full, empty};
      RegCtrl:   rd_mux = {8'h0, watermark_q, 2'b00, irq_en_err_q, irq_en_level_q,
                           4'h0, stop_size_q, parity_type_q, parity_size_q,
                           data_size_q, 3'b000, en_q};
      RegBaud:   rd_mux = baud_q;
      RegLevel:  rd_mux = {25'h0, level};
      default:   rd_mux = 32'h0;
    endcase

    rvalid_d = device_req_i;
    rdata_d  = rd_req ? rd_mux : 32'h0;

    irq_d = (irq_en_level_q & (level >= {3'b000, watermark_q}) & ~empty) |
            (irq_en_err_q & (ovf_q | perr_q));
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      en_q           <= 1'b0;
      data_size_q    <= 4'd8;
      parity_size_q  <= 1'b0;
      parity_type_q  <= 1'b0;
      stop_size_q    <= 2'd1;
      irq_en_level_q <= 1'b0;
      irq_en_err_q   <= 1'b0;
      watermark_q    <= 4'd0;
      baud_q         <= DefaultDiv;
      wptr_q         <= '0;
      rptr_q         <= '0;
      count_q        <= '0;
      ovf_q          <= 1'b0;
      perr_q         <= 1'b0;
      rdy_prev_q     <= 1'b0;
      rvalid_q       <= 1'b0;
      rdata_q        <= 32'h0;
      irq_q          <= 1'b0;
    end else begin
      en_q           <= en_d;
      data_size_q    <= data_size_d;
      parity_size_q  <= parity_size_d;
      parity_type_q  <= parity_type_d;
      stop_size_q    <= stop_size_d;
      irq_en_level_q <= irq_en_level_d;
      irq_en_err_q   <= irq_en_err_d;
      watermark_q    <= watermark_d;
      baud_q         <= baud_d;
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
      count_q        <= count_d;
      ovf_q          <= ovf_d;
      perr_q         <= perr_d;
      rdy_prev_q     <= rdy_prev_d;
      rvalid_q       <= rvalid_d;
      rdata_q        <= rdata_d;
      irq_q          <= irq_d;
    end
  end

  // FIFO storage write; contents need no reset since count gates every read
  always_ff @(posedge clk_i) begin
    if (rst_ni && push) begin
      mem_q[wptr_q] <= {rx_err_i, rx_data_i};
    end
  end

  assign device_rvalid_o = rvalid_q;
  assign device_rdata_o  = rdata_q;
  assign rx_en_o         = en_q;
  assign baud_rate_o     = baud_q;
  assign data_size_o     = data_size_q;
  assign parity_size_o   = parity_size_q;
  assign parity_type_o   = parity_type_q;
  assign stop_size_o     = stop_size_q;
  assign irq_o           = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_ctrl
//  Purpose  : Self-checking bench for uart_rx_ctrl. Frames driven on the
//             receiver side are pushed to an expected-data queue and popped
//             when software reads RDATA.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] addr = 32'h0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic        rvalid;
  logic [31:0] rdata;
  logic        rx_en;
  logic [31:0] baud;
  logic [3:0]  dsize;
  logic        psize;
  logic        ptype;
  logic [1:0]  ssize;
  logic [8:0]  rx_data = 9'h0;
  logic        rx_rdy = 1'b0;
  logic        rx_err = 1'b0;
  logic        irq;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb[$];
  logic        m_ovf  = 1'b0;
  logic        m_perr = 1'b0;
  logic [31:0] rd;

  uart_rx_ctrl #(.FifoDepth(DEPTH), .DefaultDiv(32'd433)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .device_req_i(req), .device_addr_i(addr), .device_we_i(we),
    .device_be_i(be), .device_wdata_i(wdata),
    .device_rvalid_o(rvalid), .device_rdata_o(rdata),
    .rx_en_o(rx_en), .baud_rate_o(baud), .data_size_o(dsize),
    .parity_size_o(psize), .parity_type_o(ptype), .stop_size_o(ssize),
    .rx_data_i(rx_data), .rx_rdy_i(rx_rdy), .rx_err_i(rx_err),
    .irq_o(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    return {28'h0, m_perr, m_ovf, (sb.size() == DEPTH), (sb.size() == 0)};
  endfunction

  task automatic bus_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] r);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    check_eq("rvalid", {31'h0, rvalid}, 32'h1);
    r = rdata;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus_xfer(1'b1, a, d, r);
    check_eq("wr_rdata_zero", r, 32'h0);
  endtask

  task automatic read_data();
    logic [31:0] r;
    logic [31:0] e;
    bus_xfer(1'b0, 32'h0, 32'h0, r);
    e = (sb.size() == 0) ? 32'h8000_0000 : sb.pop_front();
    check_eq("rdata_fifo", r, e);
  endtask

  task automatic check_level();
    logic [31:0] r;
    bus_xfer(1'b0, 32'h10, 32'h0, r);
    check_eq("level", r, sb.size());
  endtask

  task automatic check_status();
    logic [31:0] r;
    bus_xfer(1'b0, 32'h4, 32'h0, r);
    check_eq("status", r, exp_status());
  endtask

  // Drive one completed frame; the scoreboard mirrors FIFO acceptance
  task automatic send_frame(input logic [8:0] d, input logic e, input int hold);
    @(negedge clk);
    rx_data = d; rx_err = e; rx_rdy = 1'b1;
    if (sb.size() < DEPTH) sb.push_back({22'h0, e, d});
    else                   m_ovf = 1'b1;
    if (e) m_perr = 1'b1;
    repeat (hold) @(negedge clk);
    rx_rdy = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_en"},     {31'h0, rx_en}, 32'h0);
    check_eq({tag, "_baud"},   baud, 32'd433);
    check_eq({tag, "_dsize"},  {28'h0, dsize}, 32'd8);
    check_eq({tag, "_par"},    {30'h0, psize, ptype}, 32'h0);
    check_eq({tag, "_stop"},   {30'h0, ssize}, 32'd1);
    check_eq({tag, "_rvalid"}, {31'h0, rvalid}, 32'h0);
    check_eq({tag, "_rdata"},  rdata, 32'h0);
    check_eq({tag, "_irq"},    {31'h0, irq}, 32'h0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    check_status();
    check_level();

    // Basic capture: 8N1 enabled, BAUD 15
    bus_write(32'hC, 32'd15);
    bus_write(32'h8, 32'h081);
    check_eq("baud_out", baud, 32'd15);
    check_eq("en_out", {31'h0, rx_en}, 32'h1);
    check_eq("stop_out", {30'h0, ssize}, 32'h0);
    bus_xfer(1'b0, 32'h8, 32'h0, rd);
    check_eq("ctrl_rb", rd, 32'h081);
    send_frame(9'h0A5, 1'b0, 3);
    check_level();
    read_data();
    read_data();

    // Parity error with error interrupt enabled
    bus_write(32'h8, 32'h0002_0181);
    check_eq("psize_out", {31'h0, psize}, 32'h1);
    send_frame(9'h03C, 1'b1, 3);
    check_status();
    read_data();
    check_eq("irq_err_set", {31'h0, irq}, 32'h1);
    bus_write(32'h4, 32'h8);
    m_perr = 1'b0;
    check_eq("irq_err_hold", {31'h0, irq}, 32'h1);
    @(negedge clk);
    check_eq("irq_err_drop", {31'h0, irq}, 32'h0);
    check_status();

    // Overflow: DEPTH+1 frames without reading
    bus_write(32'h8, 32'h081);
    for (int i = 0; i <= DEPTH; i++) send_frame(9'(i), 1'b0, 2);
    check_status();
    for (int i = 0; i <= DEPTH; i++) read_data();
    check_status();
    bus_write(32'h4, 32'h4);
    m_ovf = 1'b0;
    check_status();

    // Simultaneous push and pop with a full FIFO
    for (int i = 0; i < DEPTH; i++) send_frame(9'h040 + 9'(i), 1'b0, 2);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h0;
    rx_data = 9'h1FF; rx_err = 1'b0; rx_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; rx_rdy = 1'b0;
    check_eq("simul_rvalid", {31'h0, rvalid}, 32'h1);
    check_eq("simul_head", rdata, sb.pop_front());
    sb.push_back(32'h1FF);
    repeat (2) @(negedge clk);
    check_level();
    check_status();
    for (int i = 0; i < DEPTH; i++) read_data();

    // Watermark interrupt: watermark 4, level interrupt enabled
    bus_write(32'h8, 32'h0041_0081);
    for (int i = 0; i < 3; i++) send_frame(9'h100 + 9'(i), 1'b0, 2);
    check_eq("irq_wm_below", {31'h0, irq}, 32'h0);
    @(negedge clk);
    rx_data = 9'h0F4; rx_err = 1'b0; rx_rdy = 1'b1;
    sb.push_back(32'h0F4);
    @(negedge clk);
    check_eq("irq_wm_c1", {31'h0, irq}, 32'h0);
    @(negedge clk);
    check_eq("irq_wm_c2", {31'h0, irq}, 32'h1);
    rx_rdy = 1'b0;
    repeat (2) @(negedge clk);
    read_data();
    @(negedge clk);
    check_eq("irq_wm_drop", {31'h0, irq}, 32'h0);

    // Flush with 5 queued entries; long ready pulse counts once
    send_frame(9'h0AA, 1'b1, 10);
    send_frame(9'h055, 1'b0, 2);
    check_level();
    bus_write(32'h8, 32'h8000_0081);
    sb.delete();
    check_level();
    check_status();

    // Mid-frame reset with a frame completing across reset release
    bus_write(32'h8, 32'h0011_0081);
    bus_write(32'hC, 32'd99);
    send_frame(9'h011, 1'b0, 2);
    check_eq("irq_pre_rst", {31'h0, irq}, 32'h1);
    @(negedge clk);
    rx_data = 9'h155; rx_err = 1'b0; rx_rdy = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    sb.delete();
    m_ovf = 1'b0;
    m_perr = 1'b0;
    rst_n = 1'b1;
    sb.push_back(32'h155);
    repeat (4) @(negedge clk);
    rx_rdy = 1'b0;
    repeat (2) @(negedge clk);
    check_level();
    read_data();
    check_status();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
